// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV64I multi-cycle control path:
// opcode values, controller states, ALU operations and ALU operand-B selects.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ADDR,
        MEM_RD,
        MEM_WR,
        WB_ALU,
        WB_MEM,
        BRANCH,
        TRAP
    } mc_state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle controller for the RV64I core: sequences each instruction,
// owns the shared memory port handshake and counts retired instructions.
module riscv_mc_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_data,
    output logic             pc_we,
    output logic             pc_src,
    output logic             ir_we,
    output logic             rf_we,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    mc_state_t state;
    mc_state_t next_state;
    logic      branch_known;
    logic      branch_taken;
    logic      retire;

    assign branch_known = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
    assign branch_taken = ((funct3 == F3_BEQ) &&  alu_zero) ||
                          ((funct3 == F3_BNE) && !alu_zero);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            FETCH:  if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:               next_state = EXEC_R;
                    OP_I:               next_state = EXEC_I;
                    OP_LOAD, OP_STORE:  next_state = ADDR;
                    OP_BRANCH:          next_state = BRANCH;
                    default:            next_state = TRAP;
                endcase
            end
            EXEC_R: next_state = WB_ALU;
            EXEC_I: next_state = WB_ALU;
            ADDR:   next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD: if (mem_ready) next_state = WB_MEM;
            MEM_WR: begin
                if (mem_ready) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end
            end
            WB_ALU, WB_MEM: begin
                next_state = FETCH;
                retire     = 1'b1;
            end
            BRANCH: begin
                next_state = branch_known ? FETCH : TRAP;
                retire     = branch_known;
            end
            TRAP:    next_state = TRAP;
            default: next_state = TRAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= next_state;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    // Outputs follow the state register; reset forces them all low so no
    // request is issued until the cycle after reset is released.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        ir_we        = 1'b0;
        rf_we        = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        trap         = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                DECODE: alu_src_b = SRC_B_IMM;
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_FUNCT;
                end
                ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                MEM_RD: begin
                    mem_req      = 1'b1;
                    mem_sel_data = 1'b1;
                end
                MEM_WR: begin
                    mem_req      = 1'b1;
                    mem_sel_data = 1'b1;
                    mem_we       = 1'b1;
                end
                WB_ALU: rf_we = 1'b1;
                WB_MEM: begin
                    rf_we      = 1'b1;
                    mem_to_reg = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_we     = branch_taken;
                    pc_src    = branch_taken;
                end
                TRAP:    trap = 1'b1;
                default: trap = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: walks R, load-with-waits, store, branch,
// counter wrap and trap sequences against hand-computed control values.
module tb_riscv_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_sel_data, pc_we, pc_src, ir_we;
    logic       rf_we, mem_to_reg, alu_src_a, trap;
    logic [1:0] alu_src_b, alu_op;
    logic [2:0] retired;

    int n_cmp  = 0;
    int n_fail = 0;

    // Narrow counter so the wrap is reached after eight instructions.
    riscv_mc_ctrl #(.CNT_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_sel_data(mem_sel_data), .pc_we(pc_we),
        .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic run_rtype(input logic [2:0] exp_after);
        opcode = 7'b0110011;
        step();
        step();
        step();
        chk("rtype_wb_rf_we", rf_we, 1);
        step();
        chk("rtype_retired", retired, exp_after);
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = 7'b0110011;
        funct3    = 3'b000;
        alu_zero  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_retired", retired, 0);
        chk("rst_trap", trap, 0);

        // Release: FETCH is live immediately.
        reset = 1'b1;
        #1;
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_ir_we", ir_we, 1);
        chk("fetch_pc_we", pc_we, 1);
        chk("fetch_src_b", alu_src_b, 2'b01);
        chk("fetch_sel", mem_sel_data, 0);
        step();
        chk("dec_mem_req", mem_req, 0);
        chk("dec_src_b", alu_src_b, 2'b10);
        chk("dec_rf_we", rf_we, 0);
        step();
        chk("exr_src_a", alu_src_a, 1);
        chk("exr_src_b", alu_src_b, 2'b00);
        chk("exr_alu_op", alu_op, 2'b10);
        chk("exr_rf_we", rf_we, 0);
        step();
        chk("wb_rf_we", rf_we, 1);
        chk("wb_mem_to_reg", mem_to_reg, 0);
        chk("wb_retired_pre", retired, 0);
        step();
        chk("r_retired", retired, 1);
        chk("r_next_fetch", mem_req, 1);

        // Load: two wait cycles in FETCH and in MEM_RD.
        opcode    = 7'b0000011;
        mem_ready = 1'b0;
        #1;
        chk("ldf_w0_req", mem_req, 1);
        chk("ldf_w0_ir_we", ir_we, 0);
        chk("ldf_w0_pc_we", pc_we, 0);
        step();
        chk("ldf_w1_req", mem_req, 1);
        chk("ldf_w1_ir_we", ir_we, 0);
        step();
        mem_ready = 1'b1;
        #1;
        chk("ldf_rdy_ir_we", ir_we, 1);
        step();
        step();
        chk("addr_src_a", alu_src_a, 1);
        chk("addr_src_b", alu_src_b, 2'b10);
        chk("addr_alu_op", alu_op, 2'b00);
        chk("addr_mem_req", mem_req, 0);
        step();
        mem_ready = 1'b0;
        #1;
        chk("mrd_w0_req", mem_req, 1);
        chk("mrd_w0_sel", mem_sel_data, 1);
        chk("mrd_w0_we", mem_we, 0);
        step();
        chk("mrd_w1_req", mem_req, 1);
        chk("mrd_w1_sel", mem_sel_data, 1);
        step();
        mem_ready = 1'b1;
        chk("mrd_w2_req", mem_req, 1);
        step();
        chk("wbm_rf_we", rf_we, 1);
        chk("wbm_mem_to_reg", mem_to_reg, 1);
        chk("wbm_retired_pre", retired, 1);
        step();
        chk("ld_retired", retired, 2);

        // Store.
        opcode = 7'b0100011;
        step();
        step();
        step();
        chk("mwr_req", mem_req, 1);
        chk("mwr_we", mem_we, 1);
        chk("mwr_sel", mem_sel_data, 1);
        chk("mwr_retired_pre", retired, 2);
        step();
        chk("st_retired", retired, 3);

        // BEQ taken.
        opcode   = 7'b1100011;
        funct3   = 3'b000;
        alu_zero = 1'b1;
        step();
        step();
        chk("beq_pc_we", pc_we, 1);
        chk("beq_pc_src", pc_src, 1);
        chk("beq_alu_op", alu_op, 2'b01);
        chk("beq_src_a", alu_src_a, 1);
        step();
        chk("beq_retired", retired, 4);

        // BNE with zero set: not taken.
        funct3 = 3'b001;
        step();
        step();
        chk("bne_pc_we", pc_we, 0);
        step();
        chk("bne_retired", retired, 5);

        // Counter reaches 7 then wraps to 0.
        run_rtype(3'd6);
        run_rtype(3'd7);
        run_rtype(3'd0);

        // Illegal opcode: absorbing trap.
        opcode = 7'b1111111;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("trap_flag", trap, 1);
            chk("trap_mem_req", mem_req, 0);
            chk("trap_ir_we", ir_we, 0);
            step();
        end
        chk("trap_retired", retired, 0);
        reset = 1'b0;
        step();
        chk("trap_rst_trap", trap, 0);
        chk("trap_rst_req", mem_req, 0);
        reset = 1'b1;
        #1;
        chk("trap_rel_req", mem_req, 1);
        chk("trap_rel_trap", trap, 0);
        chk("trap_rel_retired", retired, 0);

        // Branch with unsupported funct3 traps without retiring.
        opcode = 7'b1100011;
        funct3 = 3'b100;
        step();
        step();
        step();
        chk("badbr_trap", trap, 1);
        chk("badbr_retired", retired, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle control unit for the RV64I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Fetch and data accesses share a single variable-latency memory port through a request/ready handshake, so this block also owns that shared port. It drives every enable and mux select of the datapath (PC, IR, register file, ALU, memory), flags illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge.
- `opcode`  in  7  `IR[6:0]`; valid from DECODE onward.
- `funct3`  in  3  `IR[14:12]`.
- `alu_zero`  in  1  ALU zero flag, combinational from the datapath.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  write request (store); valid with `mem_req`.
- `mem_sel_data`  out  1  0 = address from PC (fetch), 1 = address from ALU_out (load/store).
- `pc_we`  out  1  PC load enable.
- `pc_src`  out  1  0 = ALU result, 1 = ALU_out register.
- `ir_we`  out  1  instruction register load.
- `rf_we`  out  1  register file write.
- `mem_to_reg`  out  1  writeback source: 0 = ALU_out, 1 = MDR.
- `alu_src_a`  out  1  0 = PC, 1 = rs1.
- `alu_src_b`  out  2  00 = rs2, 01 = const 4, 10 = immediate.
- `alu_op`  out  2  00 = ADD, 01 = SUB, 10 = FUNCT (ALU decoder uses funct3/funct7).
- `trap`  out  1  illegal opcode seen; sticky.
- `retired`  out  CNT_W  instructions completed since reset.

## Operation
States:
- FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP.

Transitions:
- FETCH: `mem_req`=1, `mem_sel_data`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD. When `mem_ready`=1, assert `ir_we` and `pc_we` with `pc_src`=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE computes the branch target into ALU_out (`alu_src_a`=0, `alu_src_b`=10, ADD). Next state by `opcode`:
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → ADDR.
  - 1100011 → BRANCH.
  - any other → TRAP.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, FUNCT → WB_ALU.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, FUNCT → WB_ALU.
- ADDR: rs1 + imm (ADD) → MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_req`=1, `mem_sel_data`=1, `mem_we`=0; on `mem_ready` → WB_MEM.
- MEM_WR: `mem_req`=1, `mem_sel_data`=1, `mem_we`=1; on `mem_ready` → FETCH (retire).
- WB_ALU: `rf_we`=1, `mem_to_reg`=0 → FETCH (retire).
- WB_MEM: `rf_we`=1, `mem_to_reg`=1 → FETCH (retire).
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, SUB.
  - Taken when (funct3=000 and `alu_zero`) or (funct3=001 and !`alu_zero`); then `pc_we`=1, `pc_src`=1.
  - funct3 other than 000/001 → TRAP.
  - Otherwise → FETCH (retire).
- TRAP: `trap`=1; all enables and `mem_req` are 0. Absorbing until reset.

Output rules:
- Outputs not listed for a state are 0.
- All outputs are decoded from the state register. `ir_we` and `pc_we` in FETCH, and `pc_we` in BRANCH, are additionally qualified combinationally (by `mem_ready` and the taken condition respectively).

Retire counter:
- `retired` increments by 1 on the cycle that leaves WB_ALU, WB_MEM, MEM_WR (with `mem_ready`) or BRANCH for FETCH.
- Wraps modulo 2^CNT_W.

## Timing
- Reset (`reset`=0 at an edge):
  - State becomes FETCH, `retired`=0, `trap`=0.
  - During reset all outputs are 0, including `mem_req`.
  - The first request is issued in the cycle after `reset` rises.
  - Reset mid-transaction abandons the request; the memory must tolerate `mem_req` dropping without `mem_ready`.
- Handshake:
  - `mem_req` rises on state entry and stays high, with stable `mem_we`/`mem_sel_data`, until the cycle in which `mem_ready`=1.
  - The transfer completes in that cycle, and `mem_req` may stay high into the next request.
  - `mem_ready` while `mem_req`=0 is ignored.
- Zero-wait cycle counts (`mem_ready` tied 1):
  - R/I: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- Branch targets and the state update take effect on the next edge; there is no speculation.

## Structure
- `riscv_pkg` holds:
  - the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - the state enum `mc_state_t`;
  - the ALU op enum `alu_op_t` and the `alu_src_b` encodings.
- Single module, no sub-module. The next-state logic, output decode and retire counter are small enough to stay inline.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 → `mem_req`=1 on the first cycle after release, `retired`=0, `trap`=0.
- R-type ADD (opcode 0110011) with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, WB_ALU; `rf_we`=1 only in WB_ALU; `retired` goes 0→1 after 4 cycles.
- Load with `mem_ready` low for 2 cycles in both FETCH and MEM_RD → 9 cycles total; `mem_req` continuously high during each wait; `mem_to_reg`=1 in WB_MEM.
- BEQ with `alu_zero`=1 → `pc_we`=1 and `pc_src`=1 in BRANCH. BNE with `alu_zero`=1 → `pc_we`=0. Both retire after 3 cycles.
- Opcode 1111111 → TRAP after DECODE; `trap` stays 1 and `mem_req` stays 0 for 10 cycles; `reset` pulse clears `trap` and restarts FETCH.
- `retired` preset to 2^CNT_W−1 via forced state, then one R-type instruction → wraps to 0.
